// File: rtl/starbug_regfile.sv
// ============================================================================
// Module   : starbug_regfile
// Purpose  : Dual-lane (2W/4R) integer register file with write-conflict stats.
//            Optional macro STARBUG_REGFILE_BYPASS_EN adds same-cycle bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module starbug_regfile #(
    parameter int XLEN    = 64,
    parameter int NUMREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    // lane 0
    input  logic [4:0]      a1_ieu,
    input  logic [4:0]      a2_ieu,
    output logic [XLEN-1:0] rd1_ieu,
    output logic [XLEN-1:0] rd2_ieu,
    input  logic            we3_ieu,
    input  logic [4:0]      a3_ieu,
    input  logic [XLEN-1:0] wd3_ieu,
    // lane 1
    input  logic [4:0]      a1_ieu1,
    input  logic [4:0]      a2_ieu1,
    output logic [XLEN-1:0] rd1_ieu1,
    output logic [XLEN-1:0] rd2_ieu1,
    input  logic            we3_ieu1,
    input  logic [4:0]      a3_ieu1,
    input  logic [XLEN-1:0] wd3_ieu1,
    // conflict statistics
    output logic            WriteConflictW,
    output logic [31:0]     ConflictCount
);

    localparam logic [31:0] c_COUNT_MAX = 32'hFFFF_FFFF;

    logic [XLEN-1:0] r_regs [1:NUMREGS-1];
    logic            r_conflict_w;
    logic [31:0]     r_conflict_count;

    logic [4:0]      w_wa0;
    logic [4:0]      w_wa1;
    logic            w_we0;
    logic            w_we1;
    logic            w_conflict;

    // The E-base file ignores address bit 4, so 17 aliases 1.
    function automatic logic [4:0] f_idx(input logic [4:0] a);
        if (NUMREGS == 16)
            f_idx = {1'b0, a[3:0]};
        else
            f_idx = a;
    endfunction

    function automatic logic [XLEN-1:0] f_read(input logic [4:0] a);
        logic [4:0] ai;
        ai     = f_idx(a);
        f_read = '0;
        if (ai != 5'd0) begin
            f_read = r_regs[ai];
`ifdef STARBUG_REGFILE_BYPASS_EN
            if (w_we1 && (w_wa1 == ai))
                f_read = wd3_ieu1;
            else if (w_we0 && (w_wa0 == ai))
                f_read = wd3_ieu;
`endif
        end
    endfunction

    assign w_wa0      = f_idx(a3_ieu);
    assign w_wa1      = f_idx(a3_ieu1);
    assign w_we0      = we3_ieu  && (w_wa0 != 5'd0);
    assign w_we1      = we3_ieu1 && (w_wa1 != 5'd0);
    assign w_conflict = w_we0 && w_we1 && (w_wa0 == w_wa1);

    always_comb begin
        rd1_ieu  = f_read(a1_ieu);
        rd2_ieu  = f_read(a2_ieu);
        rd1_ieu1 = f_read(a1_ieu1);
        rd2_ieu1 = f_read(a2_ieu1);
    end

    // Lane 1 is younger in program order, so it owns a shared destination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUMREGS; i++)
                r_regs[i] <= '0;
        end else begin
            if (w_we0 && !w_conflict)
                r_regs[w_wa0] <= wd3_ieu;
            if (w_we1)
                r_regs[w_wa1] <= wd3_ieu1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict_w     <= 1'b0;
            r_conflict_count <= '0;
        end else begin
            r_conflict_w <= w_conflict;
            if (w_conflict && (r_conflict_count != c_COUNT_MAX))
                r_conflict_count <= r_conflict_count + 32'd1;
        end
    end

    assign WriteConflictW = r_conflict_w;
    assign ConflictCount  = r_conflict_count;

endmodule

`default_nettype wire
